dcache_st_ctrl: RTL and testbench

Store-side D-cache controller: the responder for the store queue's retire/commit interface. It accepts one committed store per cycle into a small write-through buffer, writes it into the D-cache on acceptance, and drains buffered stores to main memory over the shared `proc2mem`/`mem2proc` port, arbitrating with the load controller. It also lets in-flight memory loads forward from pending buffered stores.

---
 rtl/dcache_st_ctrl_pkg.sv | 29 ++
 rtl/dcache_st_ctrl_wb_fifo.sv | 76 +++++++
 rtl/dcache_st_ctrl.sv | 108 ++++++++++
 tb/tb_dcache_st_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_st_ctrl_pkg.sv
// Shared types for the store-side D-cache controller: address/data widths,
// memory bus commands, write-buffer entry layout and drain FSM states.
package dcache_st_ctrl_pkg;

    typedef logic [31:0] ADDR;
    typedef logic [63:0] DATA;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef struct packed {
        ADDR addr;
        DATA data;
    } WBEntry_t;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_REQ  = 1'b1
    } WB_STATE_t;

    // Forwarding compares the 8-byte word index inside the cache-sized window.
    function automatic logic fwd_match(input ADDR a, input ADDR b);
        return a[12:3] == b[12:3];
    endfunction

endpackage

// File: rtl/dcache_st_ctrl_wb_fifo.sv
// Write-through buffer: circular FIFO of committed stores plus a CAM that
// lets loads forward from the youngest pending store to the same word.
module wb_fifo
    import dcache_st_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_push,
    input  WBEntry_t       i_push_entry,
    input  logic           i_pop,
    input  logic           i_lookup_en,
    input  ADDR            i_lookup_addr,
    output WBEntry_t       o_head_entry,
    output logic [PTR_W:0] o_count,
    output logic           o_full,
    output logic           o_empty,
    output logic           o_ld_match,
    output DATA            o_ld_data
);

    WBEntry_t         r_entries [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;
    logic [PTR_W-1:0] w_idx;

    // Storage and pointer update; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_entries[r_tail] <= i_push_entry;
                r_tail            <= r_tail + 1'b1;
            end
            if (i_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_entry = r_entries[r_head];
    assign o_count      = r_count;
    assign o_full       = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty      = (r_count == '0);

    // Walk valid entries oldest to youngest so the last hit is the youngest store.
    always_comb begin
        o_ld_match = 1'b0;
        o_ld_data  = '0;
        w_idx      = r_head;
        if (i_lookup_en) begin
            for (int k = 0; k < DEPTH; k++) begin
                w_idx = r_head + PTR_W'(k);
                if (((PTR_W+1)'(k) < r_count) && fwd_match(r_entries[w_idx].addr, i_lookup_addr)) begin
                    o_ld_match = 1'b1;
                    o_ld_data  = r_entries[w_idx].data;
                end
            end
        end
    end

endmodule

// File: rtl/dcache_st_ctrl.sv
// Store-side D-cache controller: accepts committed stores into a write-through
// buffer, writes the D-cache on acceptance and drains stores to memory,
// yielding the shared port to loads unless the buffer is full.
module dcache_st_ctrl
    import dcache_st_ctrl_pkg::*;
#(
    parameter int WB_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sq_mem_en,
    input  ADDR        sq_mem_addr,
    input  DATA        sq_mem_data,
    output logic       dcachectrl_st_request_sent,
    output logic       dcache_st_wr_en,
    output ADDR        dcache_st_wr_addr,
    output DATA        dcache_st_wr_data,
    input  logic       ldctrl_mem_req,
    output logic       st_mem_owner,
    output logic [1:0] proc2mem_command,
    output ADDR        proc2mem_addr,
    output DATA        proc2mem_data,
    input  logic [3:0] mem2proc_response,
    input  logic       ld_lookup_en,
    input  ADDR        ld_lookup_addr,
    output logic       wb_ld_match,
    output DATA        wb_ld_data,
    output logic       wb_empty
);

    localparam int PTR_W = $clog2(WB_DEPTH);

    WB_STATE_t      r_state;
    WB_STATE_t      w_next_state;
    logic           w_accept;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic [PTR_W:0] w_count;
    WBEntry_t       w_head_entry;
    WBEntry_t       w_push_entry;

    // Registered full only: a pop in the same cycle does not open a slot.
    assign w_accept     = sq_mem_en && !w_full;
    assign w_pop        = (r_state == WB_REQ) && (mem2proc_response != 4'h0);
    assign w_push_entry = '{addr: sq_mem_addr, data: sq_mem_data};

    assign dcachectrl_st_request_sent = w_accept;
    assign dcache_st_wr_en            = w_accept;
    assign dcache_st_wr_addr          = sq_mem_addr;
    assign dcache_st_wr_data          = sq_mem_data;

    wb_fifo #(
        .DEPTH(WB_DEPTH)
    ) u_wb_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_accept),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_lookup_en  (ld_lookup_en),
        .i_lookup_addr(ld_lookup_addr),
        .o_head_entry (w_head_entry),
        .o_count      (w_count),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_ld_match   (wb_ld_match),
        .o_ld_data    (wb_ld_data)
    );

    // Drain FSM state register; reset abandons any in-flight store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= WB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Port arbitration and bus drive; bus outputs depend only on registered state.
    always_comb begin
        w_next_state     = r_state;
        st_mem_owner     = 1'b0;
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        case (r_state)
            WB_IDLE: begin
                if (((w_count != '0) || w_accept) && (w_full || !ldctrl_mem_req)) begin
                    w_next_state = WB_REQ;
                end
            end
            WB_REQ: begin
                st_mem_owner     = 1'b1;
                proc2mem_command = BUS_STORE;
                proc2mem_addr    = w_head_entry.addr;
                proc2mem_data    = w_head_entry.data;
                if (mem2proc_response != 4'h0) begin
                    w_next_state = WB_IDLE;
                end
            end
            default: w_next_state = WB_IDLE;
        endcase
    end

    assign wb_empty = w_empty && (r_state == WB_IDLE);

endmodule

// File: tb/tb_dcache_st_ctrl.sv
// Directed bench for dcache_st_ctrl: inputs driven on the falling edge,
// outputs checked 1 time unit later, well away from the rising edge.
module tb_dcache_st_ctrl;
    import dcache_st_ctrl_pkg::*;

    logic       clk;
    logic       reset;
    logic       sq_mem_en;
    ADDR        sq_mem_addr;
    DATA        sq_mem_data;
    logic       dcachectrl_st_request_sent;
    logic       dcache_st_wr_en;
    ADDR        dcache_st_wr_addr;
    DATA        dcache_st_wr_data;
    logic       ldctrl_mem_req;
    logic       st_mem_owner;
    logic [1:0] proc2mem_command;
    ADDR        proc2mem_addr;
    DATA        proc2mem_data;
    logic [3:0] mem2proc_response;
    logic       ld_lookup_en;
    ADDR        ld_lookup_addr;
    logic       wb_ld_match;
    DATA        wb_ld_data;
    logic       wb_empty;

    int tests = 0;
    int fails = 0;

    dcache_st_ctrl #(.WB_DEPTH(4)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .sq_mem_en                 (sq_mem_en),
        .sq_mem_addr               (sq_mem_addr),
        .sq_mem_data               (sq_mem_data),
        .dcachectrl_st_request_sent(dcachectrl_st_request_sent),
        .dcache_st_wr_en           (dcache_st_wr_en),
        .dcache_st_wr_addr         (dcache_st_wr_addr),
        .dcache_st_wr_data         (dcache_st_wr_data),
        .ldctrl_mem_req            (ldctrl_mem_req),
        .st_mem_owner              (st_mem_owner),
        .proc2mem_command          (proc2mem_command),
        .proc2mem_addr             (proc2mem_addr),
        .proc2mem_data             (proc2mem_data),
        .mem2proc_response         (mem2proc_response),
        .ld_lookup_en              (ld_lookup_en),
        .ld_lookup_addr            (ld_lookup_addr),
        .wb_ld_match               (wb_ld_match),
        .wb_ld_data                (wb_ld_data),
        .wb_empty                  (wb_empty)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a task never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle_inputs();
        sq_mem_en         = 1'b0;
        sq_mem_addr       = '0;
        sq_mem_data       = '0;
        ldctrl_mem_req    = 1'b0;
        mem2proc_response = 4'h0;
        ld_lookup_en      = 1'b0;
        ld_lookup_addr    = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        ld_lookup_en = 1'b1;
        reset = 1'b1;
        #1;
        tests++; if (proc2mem_command !== BUS_NONE) begin fails++; $display("[TB] FAIL reset_cmd got %0h want %0h", proc2mem_command, BUS_NONE); end
        tests++; if (proc2mem_addr !== 32'h0) begin fails++; $display("[TB] FAIL reset_addr got %0h want 0", proc2mem_addr); end
        tests++; if (proc2mem_data !== 64'h0) begin fails++; $display("[TB] FAIL reset_data got %0h want 0", proc2mem_data); end
        tests++; if (st_mem_owner !== 1'b0) begin fails++; $display("[TB] FAIL reset_owner got %0b want 0", st_mem_owner); end
        tests++; if (wb_empty !== 1'b1) begin fails++; $display("[TB] FAIL reset_empty got %0b want 1", wb_empty); end
        tests++; if (dcachectrl_st_request_sent !== 1'b0) begin fails++; $display("[TB] FAIL reset_sent got %0b want 0", dcachectrl_st_request_sent); end
        tests++; if (dcache_st_wr_en !== 1'b0) begin fails++; $display("[TB] FAIL reset_wr_en got %0b want 0", dcache_st_wr_en); end
        tests++; if (wb_ld_match !== 1'b0) begin fails++; $display("[TB] FAIL reset_match got %0b want 0", wb_ld_match); end
        tests++; if (wb_ld_data !== 64'h0) begin fails++; $display("[TB] FAIL reset_ld_data got %0h want 0", wb_ld_data); end
        @(negedge clk);
        reset = 1'b0;
        ld_lookup_en = 1'b0;
    endtask

    task automatic test_single_store();
        test_reset();
        @(negedge clk);
        sq_mem_en = 1'b1; sq_mem_addr = 32'h040; sq_mem_data = 64'hDEAD;
        #1;
        tests++; if (dcachectrl_st_request_sent !== 1'b1) begin fails++; $display("[TB] FAIL single_sent got %0b want 1", dcachectrl_st_request_sent); end
        tests++; if (dcache_st_wr_en !== 1'b1) begin fails++; $display("[TB] FAIL single_wr_en got %0b want 1", dcache_st_wr_en); end
        tests++; if (dcache_st_wr_addr !== 32'h040) begin fails++; $display("[TB] FAIL single_wr_addr got %0h want 40", dcache_st_wr_addr); end
        tests++; if (proc2mem_command !== BUS_NONE) begin fails++; $display("[TB] FAIL single_cmd_c0 got %0h want %0h", proc2mem_command, BUS_NONE); end
        @(negedge clk);
        sq_mem_en = 1'b0;
        #1;
        tests++; if (proc2mem_command !== BUS_STORE) begin fails++; $display("[TB] FAIL single_cmd_c1 got %0h want %0h", proc2mem_command, BUS_STORE); end
        tests++; if (proc2mem_addr !== 32'h040) begin fails++; $display("[TB] FAIL single_addr got %0h want 40", proc2mem_addr); end
        tests++; if (proc2mem_data !== 64'hDEAD) begin fails++; $display("[TB] FAIL single_data got %0h want dead", proc2mem_data); end
        tests++; if (st_mem_owner !== 1'b1) begin fails++; $display("[TB] FAIL single_owner got %0b want 1", st_mem_owner); end
        @(negedge clk);
        mem2proc_response = 4'h3;
        #1;
        tests++; if (proc2mem_command !== BUS_STORE) begin fails++; $display("[TB] FAIL single_cmd_c2 got %0h want %0h", proc2mem_command, BUS_STORE); end
        tests++; if (wb_empty !== 1'b0) begin fails++; $display("[TB] FAIL single_empty_c2 got %0b want 0", wb_empty); end
        @(negedge clk);
        mem2proc_response = 4'h0;
        #1;
        tests++; if (wb_empty !== 1'b1) begin fails++; $display("[TB] FAIL single_empty_c3 got %0b want 1", wb_empty); end
        tests++; if (proc2mem_command !== BUS_NONE) begin fails++; $display("[TB] FAIL single_cmd_c3 got %0h want %0h", proc2mem_command, BUS_NONE); end
    endtask

    task automatic test_fill_full();
        test_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sq_mem_en = 1'b1; sq_mem_addr = 32'h100 + 32'(8 * i); sq_mem_data = 64'hA0 + 64'(i);
            #1;
            tests++; if (dcachectrl_st_request_sent !== (i < 4)) begin fails++; $display("[TB] FAIL full_sent[%0d] got %0b want %0b", i, dcachectrl_st_request_sent, (i < 4)); end
            if (i > 0) begin
                tests++; if (proc2mem_command !== BUS_STORE || proc2mem_addr !== 32'h100) begin fails++; $display("[TB] FAIL full_hold[%0d] got cmd %0h addr %0h want cmd %0h addr 100", i, proc2mem_command, proc2mem_addr, BUS_STORE); end
            end
        end
        @(negedge clk);
        sq_mem_en = 1'b0;
        #1;
        tests++; if (proc2mem_data !== 64'hA0) begin fails++; $display("[TB] FAIL full_head_data got %0h want a0", proc2mem_data); end
    endtask

    task automatic test_load_priority();
        test_reset();
        ldctrl_mem_req = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            sq_mem_en = (c == 0 || c == 1 || c == 4 || c == 5);
            sq_mem_addr = 32'h200 + 32'(8 * c);
            sq_mem_data = 64'hB0 + 64'(c);
            #1;
            tests++; if (st_mem_owner !== (c == 7)) begin fails++; $display("[TB] FAIL ldprio_owner[%0d] got %0b want %0b", c, st_mem_owner, (c == 7)); end
        end
        tests++; if (proc2mem_addr !== 32'h200) begin fails++; $display("[TB] FAIL ldprio_addr got %0h want 200", proc2mem_addr); end
        sq_mem_en = 1'b0;
    endtask

    task automatic test_forwarding();
        test_reset();
        ldctrl_mem_req = 1'b1;
        @(negedge clk);
        sq_mem_en = 1'b1; sq_mem_addr = 32'h080; sq_mem_data = 64'h1;
        @(negedge clk);
        sq_mem_data = 64'h2;
        @(negedge clk);
        sq_mem_addr = 32'h098; sq_mem_data = 64'h5;
        @(negedge clk);
        sq_mem_en = 1'b0;
        ld_lookup_en = 1'b1; ld_lookup_addr = 32'h080;
        #1;
        tests++; if (wb_ld_match !== 1'b1 || wb_ld_data !== 64'h2) begin fails++; $display("[TB] FAIL fwd_080 got %0b/%0h want 1/2", wb_ld_match, wb_ld_data); end
        ld_lookup_addr = 32'h084;
        #1;
        tests++; if (wb_ld_match !== 1'b1 || wb_ld_data !== 64'h2) begin fails++; $display("[TB] FAIL fwd_084 got %0b/%0h want 1/2", wb_ld_match, wb_ld_data); end
        ld_lookup_addr = 32'h088;
        #1;
        tests++; if (wb_ld_match !== 1'b0) begin fails++; $display("[TB] FAIL fwd_088 got %0b want 0", wb_ld_match); end
        ld_lookup_addr = 32'h098;
        #1;
        tests++; if (wb_ld_match !== 1'b1 || wb_ld_data !== 64'h5) begin fails++; $display("[TB] FAIL fwd_098 got %0b/%0h want 1/5", wb_ld_match, wb_ld_data); end
        ld_lookup_en = 1'b0; ld_lookup_addr = 32'h080;
        #1;
        tests++; if (wb_ld_match !== 1'b0) begin fails++; $display("[TB] FAIL fwd_disabled got %0b want 0", wb_ld_match); end
    endtask

    task automatic test_back_to_back();
        int   sent;
        int   popped;
        int   mcount;
        logic mreq;
        logic exp_acc;
        test_reset();
        sent = 0; popped = 0; mcount = 0; mreq = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (sent == 10 && popped == 10 && !mreq) break;
            @(negedge clk);
            sq_mem_en = (sent < 10);
            sq_mem_addr = 32'h300 + 32'(8 * sent);
            sq_mem_data = 64'h1000 + 64'(sent);
            mem2proc_response = 4'h1;
            #1;
            exp_acc = (sent < 10) && (mcount < 4);
            tests++; if (dcachectrl_st_request_sent !== exp_acc) begin fails++; $display("[TB] FAIL wrap_sent[c%0d] got %0b want %0b", c, dcachectrl_st_request_sent, exp_acc); end
            tests++; if (proc2mem_command !== (mreq ? BUS_STORE : BUS_NONE)) begin fails++; $display("[TB] FAIL wrap_cmd[c%0d] got %0h want %0h", c, proc2mem_command, (mreq ? BUS_STORE : BUS_NONE)); end
            if (mreq) begin
                tests++; if (proc2mem_addr !== 32'h300 + 32'(8 * popped) || proc2mem_data !== 64'h1000 + 64'(popped)) begin fails++; $display("[TB] FAIL wrap_order[c%0d] got %0h/%0h want %0h/%0h", c, proc2mem_addr, proc2mem_data, 32'h300 + 32'(8 * popped), 64'h1000 + 64'(popped)); end
            end
            if (mreq) begin
                popped++;
                mcount--;
                mreq = 1'b0;
            end else if (mcount > 0 || exp_acc) begin
                mreq = 1'b1;
            end
            if (exp_acc) begin
                sent++;
                mcount++;
            end
        end
        @(negedge clk);
        sq_mem_en = 1'b0; mem2proc_response = 4'h0;
        #1;
        tests++; if (wb_empty !== 1'b1) begin fails++; $display("[TB] FAIL wrap_final_empty got %0b want 1", wb_empty); end
    endtask

    task automatic test_async_reset();
        test_reset();
        @(negedge clk);
        sq_mem_en = 1'b1; sq_mem_addr = 32'h500; sq_mem_data = 64'h77;
        @(negedge clk);
        sq_mem_en = 1'b0;
        #1;
        tests++; if (proc2mem_command !== BUS_STORE) begin fails++; $display("[TB] FAIL areset_pre_cmd got %0h want %0h", proc2mem_command, BUS_STORE); end
        #1;
        reset = 1'b1;
        #1;
        tests++; if (proc2mem_command !== BUS_NONE) begin fails++; $display("[TB] FAIL areset_cmd got %0h want %0h", proc2mem_command, BUS_NONE); end
        tests++; if (proc2mem_addr !== 32'h0) begin fails++; $display("[TB] FAIL areset_addr got %0h want 0", proc2mem_addr); end
        tests++; if (wb_empty !== 1'b1) begin fails++; $display("[TB] FAIL areset_empty got %0b want 1", wb_empty); end
        tests++; if (st_mem_owner !== 1'b0) begin fails++; $display("[TB] FAIL areset_owner got %0b want 0", st_mem_owner); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_single_store();
        test_fill_full();
        test_load_priority();
        test_forwarding();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
